// File: rtl/mac_sched_if.sv
// Nonzero input stream, vector-memory read port and mac write/result port of mac_sched.
// slave is the scheduler side; master is the environment (source, memory, mac) side.
interface mac_sched_if #(
  parameter int ROW_W = 10,
  parameter int COL_W = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [ROW_W-1:0] in_row;
  logic [COL_W-1:0] in_col;
  logic [63:0]      in_val;

  logic             vec_rd_en;
  logic [COL_W-1:0] vec_rd_addr;
  logic [63:0]      vec_rd_data;

  logic             mac_wr;
  logic [ROW_W-1:0] mac_row;
  logic [63:0]      mac_v0;
  logic [63:0]      mac_v1;
  logic             mac_eof;
  logic             mac_push;

  modport master (
    output in_valid, in_row, in_col, in_val, vec_rd_data, mac_push,
    input  in_ready, vec_rd_en, vec_rd_addr, mac_wr, mac_row, mac_v0, mac_v1, mac_eof
  );

  modport slave (
    input  in_valid, in_row, in_col, in_val, vec_rd_data, mac_push,
    output in_ready, vec_rd_en, vec_rd_addr, mac_wr, mac_row, mac_v0, mac_v1, mac_eof
  );
endinterface

// File: rtl/mac_sched.sv
// mac_sched: feeds one sparse-matrix block into the mac -- issues x[col] reads, pairs each
// read with its nonzero, then drains, strobes eof and waits for the mac to go quiet.
module mac_sched #(
  parameter int INTERMEDIATOR_DEPTH      = 1024,
  parameter int LOG2_INTERMEDIATOR_DEPTH = $clog2(INTERMEDIATOR_DEPTH - 1),
  parameter int COL_WIDTH                = 20,
  parameter int VEC_LATENCY              = 3,
  parameter int FLUSH_CYCLES             = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_nnz_count,
  mac_sched_if.slave  bus,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_out_count
);
  localparam int RW = LOG2_INTERMEDIATOR_DEPTH;
  localparam int QW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [QW-1:0] QUIET_LAST = QW'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_EOF   = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_remaining;
  logic [31:0]     r_out_count;
  logic [QW-1:0]   r_quiet;

  logic [VEC_LATENCY-1:0] r_pipe_vld;
  logic [RW-1:0]          r_pipe_row [VEC_LATENCY];
  logic [63:0]            r_pipe_val [VEC_LATENCY];

  logic            r_mac_wr;
  logic [RW-1:0]   r_mac_row;
  logic [63:0]     r_mac_v0;
  logic [63:0]     r_mac_v1;

  logic            w_in_ready;
  logic            w_hs;
  logic            w_pipe_busy;
  logic            w_quiet_done;

  // in_ready depends only on state and remaining so the source never sees a combinational loop.
  assign w_in_ready   = (r_state == S_RUN) && (r_remaining != 32'd0);
  assign w_hs         = w_in_ready && bus.in_valid;
  assign w_pipe_busy  = (|r_pipe_vld) || r_mac_wr;
  assign w_quiet_done = !bus.mac_push && (r_quiet == QUIET_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_nnz_count != 32'd0) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_hs && (r_remaining == 32'd1)) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        if (!w_pipe_busy) begin
          w_state_nxt = S_EOF;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_EOF:   w_state_nxt = S_FLUSH;
      S_FLUSH: begin
        if (w_quiet_done) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_remaining <= 32'd0;
      r_out_count <= 32'd0;
      r_quiet     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        if (i_start) begin
          r_remaining <= i_nnz_count;
          r_out_count <= 32'd0;
        end
      end else begin
        if (w_hs) begin
          r_remaining <= r_remaining - 32'd1;
        end
        if (bus.mac_push && (r_out_count != 32'hFFFF_FFFF)) begin
          r_out_count <= r_out_count + 32'd1;
        end
      end
      // Quiet only advances inside FLUSH; any push restarts the count.
      if ((r_state != S_FLUSH) || bus.mac_push) begin
        r_quiet <= '0;
      end else begin
        r_quiet <= r_quiet + QW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < VEC_LATENCY; i++) begin
        r_pipe_row[i] <= '0;
        r_pipe_val[i] <= 64'd0;
      end
    end else begin
      r_pipe_vld[0] <= w_hs;
      r_pipe_row[0] <= bus.in_row;
      r_pipe_val[0] <= bus.in_val;
      for (int i = 1; i < VEC_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_row[i] <= r_pipe_row[i-1];
        r_pipe_val[i] <= r_pipe_val[i-1];
      end
    end
  end

  // The tail stage lines up with the memory's read data; capture both into the mac register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mac_wr  <= 1'b0;
      r_mac_row <= '0;
      r_mac_v0  <= 64'd0;
      r_mac_v1  <= 64'd0;
    end else begin
      r_mac_wr <= r_pipe_vld[VEC_LATENCY-1];
      if (r_pipe_vld[VEC_LATENCY-1]) begin
        r_mac_row <= r_pipe_row[VEC_LATENCY-1];
        r_mac_v0  <= r_pipe_val[VEC_LATENCY-1];
        r_mac_v1  <= bus.vec_rd_data;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.vec_rd_en   = w_hs;
  assign bus.vec_rd_addr = w_hs ? bus.in_col : '0;
  assign bus.mac_wr      = r_mac_wr;
  assign bus.mac_row     = r_mac_row;
  assign bus.mac_v0      = r_mac_v0;
  assign bus.mac_v1      = r_mac_v1;
  assign bus.mac_eof     = (r_state == S_EOF);
  assign o_busy          = (r_state != S_IDLE);
  assign o_done          = (r_state == S_DONE);
  assign o_out_count     = r_out_count;
endmodule

// File: tb/tb_mac_sched.sv
// Bench for mac_sched: directed and randomized blocks checked cycle by cycle against a
// timing model built from issue times (read latency, drain, eof, quiet-window rules).
module tb_mac_sched;
  localparam int RW  = 10;
  localparam int CW  = 20;
  localparam int L   = 3;
  localparam int FC  = 64;
  localparam int FAR = 32'h3fff_ffff;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] nnz_count;
  logic        busy;
  logic        done;
  logic [31:0] out_count;

  mac_sched_if #(.ROW_W(RW), .COL_W(CW)) bus ();

  mac_sched #(
    .INTERMEDIATOR_DEPTH(1024), .LOG2_INTERMEDIATOR_DEPTH(RW), .COL_WIDTH(CW),
    .VEC_LATENCY(L), .FLUSH_CYCLES(FC)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_nnz_count(nnz_count),
    .bus(bus), .o_busy(busy), .o_done(done), .o_out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            t;
    logic [RW-1:0] row;
    logic [63:0]   v0;
    logic [63:0]   v1;
  } wr_t;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          chk_en = 1'b0;
  int          cyc = 0;
  bit          m_started = 1'b0;
  int          m_s = 0;
  int          m_eof = FAR;
  int          m_done = FAR;
  int unsigned m_rem = 0;
  logic [31:0] m_out = 32'd0;
  int          idx = 0;
  wr_t         wq[$];
  logic [CW-1:0] rd_map [int];
  logic [RW-1:0] last_row = '0;
  logic [63:0]   last_v0 = 64'd0;
  logic [63:0]   last_v1 = 64'd0;

  logic [RW-1:0] nz_row [16];
  logic [CW-1:0] nz_col [16];
  logic [63:0]   nz_val [16];

  function automatic logic [63:0] vec_x(input logic [CW-1:0] a);
    case (a)
      20'd0:   return $realtobits(10.0);
      20'd1:   return $realtobits(20.0);
      20'd2:   return $realtobits(30.0);
      default: return {12'h7A5, a, 12'h3C1, ~a};
    endcase
  endfunction

  function automatic bit m_active();
    return m_started && (cyc > m_s) && (cyc <= m_done);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    if (chk_en) begin
      n_cmp++;
      assert (obs === exp) else begin
        n_err++;
        $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
      end
    end
  endtask

  // One clock: memory answers reads issued L cycles ago, outputs are checked, model advances.
  task automatic cycle();
    logic hs;
    logic wr_exp;
    bus.vec_rd_data = rd_map.exists(cyc - L) ? vec_x(rd_map[cyc - L]) : {$urandom, $urandom};
    #1;
    hs = m_active() && (m_rem != 0) && bus.in_valid;
    chk("in_ready", bus.in_ready, m_active() && (m_rem != 0));
    chk("vec_rd_en", bus.vec_rd_en, hs);
    if (hs) begin
      chk("vec_rd_addr", bus.vec_rd_addr, bus.in_col);
      rd_map[cyc] = bus.in_col;
      wq.push_back('{cyc + L + 1, bus.in_row, bus.in_val, vec_x(bus.in_col)});
      m_rem--;
      idx++;
      if (m_rem == 0) begin
        m_eof  = cyc + L + 3;
        m_done = m_eof + FC + 1;
      end
    end
    wr_exp = (wq.size() != 0) && (wq[0].t == cyc);
    chk("mac_wr", bus.mac_wr, wr_exp);
    if (wr_exp) begin
      last_row = wq[0].row;
      last_v0  = wq[0].v0;
      last_v1  = wq[0].v1;
      void'(wq.pop_front());
    end
    chk("mac_row", bus.mac_row, last_row);
    chk("mac_v0", bus.mac_v0, last_v0);
    chk("mac_v1", bus.mac_v1, last_v1);
    chk("mac_eof", bus.mac_eof, m_started && (cyc == m_eof));
    chk("done", done, m_started && (cyc == m_done));
    chk("busy", busy, m_active());
    chk("out_count", out_count, m_out);
    if (bus.mac_push && m_active()) begin
      if (m_out != 32'hFFFF_FFFF) m_out++;
      if ((cyc > m_eof) && (cyc < m_done)) m_done = cyc + FC + 1;
    end
    if (start && !m_active()) begin
      m_started = 1'b1;
      m_s   = cyc;
      m_rem = nnz_count;
      m_out = 32'd0;
      idx   = 0;
      if (nnz_count == 32'd0) begin
        m_eof  = cyc + 2;
        m_done = m_eof + FC + 1;
      end else begin
        m_eof  = FAR;
        m_done = FAR;
      end
    end
    if (rst) begin
      m_started = 1'b0;
      m_out = 32'd0;
      m_rem = 0;
      m_eof = FAR;
      m_done = FAR;
      wq.delete();
      last_row = '0;
      last_v0  = 64'd0;
      last_v1  = 64'd0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_nz(input int n, input bit v);
    bus.in_valid = v;
    if (idx < n) begin
      bus.in_row = nz_row[idx];
      bus.in_col = nz_col[idx];
      bus.in_val = nz_val[idx];
    end else begin
      bus.in_row = RW'($urandom);
      bus.in_col = CW'($urandom);
      bus.in_val = {$urandom, $urandom};
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.mac_push = 1'b0;
    for (int i = 0; i < n; i++) cycle();
    rst = 1'b0;
  endtask

  // vmode: 0 back-to-back, 1 every other cycle, 2 random. pmode: 0 random pushes,
  // 1 three pushes 40 quiet cycles apart after eof, 2 one push on the terminal quiet cycle.
  task automatic run_block(input int n, input int vmode, input int pmode, input bit noise);
    int guard;
    int pushes;
    bit v;
    guard  = 0;
    pushes = 0;
    start = 1'b1;
    nnz_count = n;
    drive_nz(n, 1'b1);
    bus.mac_push = 1'b0;
    cycle();
    start = 1'b0;
    while (m_active() && (guard < 5000)) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (guard % 2) == 1;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      drive_nz(n, v);
      case (pmode)
        1: bus.mac_push = (cyc == m_eof + 1) || (cyc == m_eof + 42) || (cyc == m_eof + 83);
        2: begin
          bus.mac_push = (pushes == 0) && (cyc == m_done - 1);
          if (bus.mac_push) pushes++;
        end
        default: bus.mac_push = ($urandom_range(0, 99) < 2);
      endcase
      if (noise) begin
        start = ($urandom_range(0, 9) == 0) || (cyc == m_done);
        nnz_count = $urandom;
      end
      cycle();
      guard++;
    end
    chk("block_timeout", guard < 5000, 1'b1);
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.mac_push = 1'b0;
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    nnz_count = 32'd0;
    bus.in_valid = 1'b0;
    bus.in_row = '0;
    bus.in_col = '0;
    bus.in_val = 64'd0;
    bus.mac_push = 1'b0;
    bus.vec_rd_data = 64'd0;
    cycle();
    chk_en = 1'b1;
    do_reset(9);
    chk("reset_out_count", out_count, 32'd0);
    chk("reset_busy", busy, 1'b0);

    nz_row[0] = 10'd0; nz_col[0] = 20'd1; nz_val[0] = $realtobits(1.0);
    nz_row[1] = 10'd0; nz_col[1] = 20'd2; nz_val[1] = $realtobits(2.0);
    nz_row[2] = 10'd1; nz_col[2] = 20'd0; nz_val[2] = $realtobits(3.0);
    nz_row[3] = 10'd2; nz_col[3] = 20'd2; nz_val[3] = $realtobits(4.0);
    run_block(4, 0, 0, 1'b0);
    run_block(4, 1, 0, 1'b0);

    run_block(0, 0, 1, 1'b0);
    chk("empty_out_count", out_count, 32'd3);
    run_block(0, 0, 2, 1'b0);
    chk("empty_term_push_count", out_count, 32'd1);

    run_block(2, 0, 1, 1'b1);
    chk("flush_out_count", out_count, 32'd3);

    start = 1'b1;
    nnz_count = 32'd4;
    drive_nz(4, 1'b0);
    cycle();
    start = 1'b0;
    for (int g = 0; (g < 20) && (idx < 2); g++) begin
      drive_nz(4, 1'b1);
      cycle();
    end
    drive_nz(4, 1'b0);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_mac_wr", bus.mac_wr, 1'b0);
    chk("rst_mac_eof", bus.mac_eof, 1'b0);
    for (int i = 0; i < 4; i++) cycle();
    nz_row[0] = 10'd7; nz_col[0] = 20'd5; nz_val[0] = {$urandom, $urandom};
    run_block(1, 0, 0, 1'b0);

    for (int b = 0; b < 6; b++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        nz_row[k] = RW'($urandom);
        nz_col[k] = (k % 5 == 0) ? CW'($urandom) : CW'($urandom_range(0, 15));
        nz_val[k] = {$urandom, $urandom};
      end
      run_block(n, 2, 0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mac_sched.md
Name: mac_sched

Overview:
- Sequencing controller for the SpMV multiply-accumulate unit (`mac`).
- Accepts a stream of nonzeros (row, col, value) for one matrix block.
- For each nonzero, reads the vector element x[col] from a fixed-latency vector memory, pairs it with the nonzero value, and drives the mac write port.
- After the last nonzero it drains the read pipeline, pulses the mac end-of-file strobe, waits for the mac to finish emitting results, then reports done with a count of results received.

Parameters:
- INTERMEDIATOR_DEPTH, 1024, row capacity of the attached mac.
- LOG2_INTERMEDIATOR_DEPTH, log2(INTERMEDIATOR_DEPTH-1), row index width (10 at default).
- COL_WIDTH, 20, vector address width.
- VEC_LATENCY, 3, fixed read latency of the vector memory in cycles (≥1).
- FLUSH_CYCLES, 64, consecutive cycles with no mac_push after eof before done is declared.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- start  in  1  begin a block; sampled only in IDLE.
- nnz_count  in  32  number of nonzeros in the block; latched on start.
- in_valid  in  1  nonzero available.
- in_ready  out  1  nonzero accepted when in_valid && in_ready.
- in_row  in  LOG2_INTERMEDIATOR_DEPTH  nonzero row index.
- in_col  in  COL_WIDTH  nonzero column index.
- in_val  in  64  nonzero value (IEEE double).
- vec_rd_en  out  1  vector read strobe.
- vec_rd_addr  out  COL_WIDTH  vector read address.
- vec_rd_data  in  64  x[addr], valid exactly VEC_LATENCY cycles after vec_rd_en.
- mac_wr  out  1  to mac wr.
- mac_row  out  LOG2_INTERMEDIATOR_DEPTH  to mac row.
- mac_v0  out  64  to mac v0 (matrix value).
- mac_v1  out  64  to mac v1 (vector value).
- mac_eof  out  1  to mac eof; single-cycle pulse.
- mac_push  in  1  from mac push_out.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at block completion.
- out_count  out  32  number of mac_push cycles seen since start.

Behaviour:
- **Reset values:** all outputs 0; state IDLE; internal counters and pipeline valid bits cleared.
- **Reset mid-operation:** aborts the block the following cycle with the same values. Reads still in flight are discarded.
- **States:** IDLE, RUN, DRAIN, EOF, FLUSH, DONE.
- **IDLE:**
  - On start: latch nnz_count into `remaining` and clear out_count.
  - If nnz_count != 0, go to RUN; otherwise go directly to DRAIN.
- **RUN:**
  - in_ready = 1 iff remaining != 0. It is combinational from state and remaining only, never from in_valid.
  - On handshake: vec_rd_en=1 and vec_rd_addr=in_col in the same cycle (combinational). {in_row, in_val} plus a valid bit enter a VEC_LATENCY-deep shift pipeline, and remaining decrements.
  - When remaining reaches 0 (on the handshake that takes it to 0), go to DRAIN next cycle.
- **Pipeline output:**
  - Registered. When the pipeline-tail valid bit is 1, the next cycle has mac_wr=1, mac_row=row, mac_v0=val, mac_v1=vec_rd_data captured at the tail.
  - Issue-to-mac_wr latency = VEC_LATENCY+1 cycles.
  - No backpressure from the mac: one nonzero per cycle, back-to-back.
  - When mac_wr=0, mac_row, mac_v0 and mac_v1 hold their last values.
- **DRAIN:** wait until all pipeline valid bits and the output register are clear, then go to EOF.
- **EOF:** mac_eof=1 for exactly one cycle, then go to FLUSH. mac_eof is never asserted in the same cycle as mac_wr.
- **FLUSH:**
  - A quiet counter resets to 0 on every mac_push and otherwise increments.
  - When quiet = FLUSH_CYCLES-1 with no push, go to DONE.
- **DONE:** done=1 for one cycle, then go to IDLE. out_count holds its value until the next start.
- **out_count:**
  - Increments on every mac_push cycle in any non-IDLE state, including RUN and DRAIN.
  - Saturates at 2^32-1.
- **Ignored inputs:**
  - start is ignored outside IDLE.
  - in_valid is ignored when in_ready=0; in_row, in_col and in_val are don't-care then.
- **Simultaneous events:**
  - In FLUSH, a mac_push in the cycle quiet would reach terminal keeps the block in FLUSH with quiet reset to 0.
  - start in the DONE cycle is ignored.

Test Plan:
- **Basic block, VEC_LATENCY=3:**
  - Stimulus: reset 10 cycles, start with nnz_count=4; nonzeros (row,col,val) = (0,1,1.0), (0,2,2.0), (1,0,3.0), (2,2,4.0) back-to-back; memory x=[10.0, 20.0, 30.0].
  - Required: vec_rd_addr 1,2,0,2 on consecutive cycles; mac_wr pairs (0,1.0,20.0), (0,2.0,30.0), (1,3.0,10.0), (2,4.0,30.0) starting exactly 4 cycles after the first handshake; a single mac_eof after the last mac_wr.
- **Input bubbles:**
  - Stimulus: same 4 nonzeros with in_valid low every other cycle.
  - Required: mac_wr has the same gaps; remaining is not decremented on idle cycles; in_ready drops to 0 after the 4th handshake.
- **Empty block:**
  - Stimulus: start with nnz_count=0.
  - Required: no vec_rd_en, no mac_wr; mac_eof pulse 1–2 cycles after start; done pulse FLUSH_CYCLES cycles after eof (no pushes); out_count=0.
- **Flush counting:**
  - Stimulus: after eof, drive mac_push for 3 cycles separated by 40 quiet cycles.
  - Required: done is not asserted until 64 quiet cycles after the last push; out_count=3.
- **Reset mid-block:**
  - Stimulus: assert rst two cycles after the 2nd handshake of a 4-nonzero block.
  - Required: next cycle busy=0, mac_wr=0, mac_eof=0; a following start with nnz_count=1 runs cleanly with exactly one mac_wr.
- **Start while busy:**
  - Stimulus: pulse start during RUN and during DONE.
  - Required: ignored; remaining and out_count are unaffected.
